// File: rtl/global_defs.sv
// Shared front-end types: instruction/address words and the fetch-to-dispatch
// instruction FIFO entry, plus the default FIFO depth.
package global_defs;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
    logic   is_cond_br;
    logic   br_dir_pred;
    addr_t  br_target_pred;
  } ififo_entry_t;

  localparam int unsigned IFIFO_N_ENTRIES = 8;

endpackage

// File: rtl/ififo_ptr.sv
// Wrap-around FIFO pointer: increments on inc, synchronous clear, synchronous
// active-low reset (reset takes priority over clear).
module ififo_ptr #(
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 inc,
  input  logic                 clr,
  output logic [PTR_WIDTH-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ififo.sv
// Instruction FIFO between fetch and dispatch with flush on fetch redirect.
// Optional same-cycle bypass of an empty FIFO under `IFIFO_BYPASS_EN.
module ififo
  import global_defs::*;
#(
  parameter int unsigned N_ENTRIES = IFIFO_N_ENTRIES,
  parameter int unsigned PTR_WIDTH = $clog2(N_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_aL,
  input  logic               fetch_ififo_valid,
  input  ififo_entry_t       fetch_ififo_data,
  output logic               fetch_ififo_ready,
  output logic               ififo_dispatch_valid,
  output ififo_entry_t       ififo_dispatch_data,
  input  logic               ififo_dispatch_ready,
  input  logic               fetch_redirect_valid,
  output logic [PTR_WIDTH:0] ififo_count
);

  localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH + 1)'(N_ENTRIES);
  localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH + 1)'(1);

  ififo_entry_t         storage [N_ENTRIES];
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH:0]   count;
  logic                 empty;
  logic                 enq;
  logic                 enq_store;
  logic                 deq_store;

  assign empty             = (count == '0);
  assign fetch_ififo_ready = (count != CNT_FULL);
  assign enq = fetch_ififo_valid & fetch_ififo_ready & ~fetch_redirect_valid;
  assign ififo_count       = count;

`ifdef IFIFO_BYPASS_EN
  logic bypass;

  // A bypassed entry taken by dispatch never touches storage, so only
  // stored entries advance head and only untaken ones are written.
  assign bypass               = empty & fetch_ififo_valid & ~fetch_redirect_valid;
  assign ififo_dispatch_valid = ~empty | bypass;
  assign ififo_dispatch_data  = bypass ? fetch_ififo_data : storage[head];
  assign deq_store = ~empty & ififo_dispatch_ready & ~fetch_redirect_valid;
  assign enq_store = enq & ~(bypass & ififo_dispatch_ready);
`else
  assign ififo_dispatch_valid = ~empty;
  assign ififo_dispatch_data  = storage[head];
  assign deq_store = ififo_dispatch_valid & ififo_dispatch_ready & ~fetch_redirect_valid;
  assign enq_store = enq;
`endif

  ififo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_head_ptr (
    .clk    (clk),
    .rst_aL (rst_aL),
    .inc    (deq_store),
    .clr    (fetch_redirect_valid),
    .ptr    (head)
  );

  ififo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_tail_ptr (
    .clk    (clk),
    .rst_aL (rst_aL),
    .inc    (enq_store),
    .clr    (fetch_redirect_valid),
    .ptr    (tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        storage[i] <= '0;
      end
    end else if (enq_store) begin
      storage[tail] <= fetch_ififo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_aL || fetch_redirect_valid) begin
      count <= '0;
    end else begin
      case ({enq_store, deq_store})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ififo.sv
// Directed, table-driven bench for ififo (default depth 8).
module tb_ififo;
  import global_defs::*;

  logic         clk = 1'b0;
  logic         rst_aL = 1'b0;
  logic         fetch_ififo_valid = 1'b0;
  ififo_entry_t fetch_ififo_data = '0;
  logic         fetch_ififo_ready;
  logic         ififo_dispatch_valid;
  ififo_entry_t ififo_dispatch_data;
  logic         ififo_dispatch_ready = 1'b0;
  logic         fetch_redirect_valid = 1'b0;
  logic [3:0]   ififo_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ififo #(.N_ENTRIES(8)) dut (
    .clk                  (clk),
    .rst_aL               (rst_aL),
    .fetch_ififo_valid    (fetch_ififo_valid),
    .fetch_ififo_data     (fetch_ififo_data),
    .fetch_ififo_ready    (fetch_ififo_ready),
    .ififo_dispatch_valid (ififo_dispatch_valid),
    .ififo_dispatch_data  (ififo_dispatch_data),
    .ififo_dispatch_ready (ififo_dispatch_ready),
    .fetch_redirect_valid (fetch_redirect_valid),
    .ififo_count          (ififo_count)
  );

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        dr;
    logic        rd;
    logic        rst_n;
    logic [3:0]  ec;
    logic        efr;
    logic        edv;
    logic [31:0] epc;
    logic        zchk;
  } vec_t;

  vec_t tbl[$];

  function automatic ififo_entry_t mk_entry(input logic [31:0] pc);
    ififo_entry_t e;
    e.instr          = {pc[15:0], 16'h0013};
    e.pc             = pc;
    e.is_cond_br     = pc[2];
    e.br_dir_pred    = pc[3];
    e.br_target_pred = pc + 32'h40;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] pc, input logic dr, input logic rd,
                     input logic rst_n, input logic [3:0] ec, input logic efr,
                     input logic edv, input logic [31:0] epc, input logic zchk);
    vec_t v;
    v.fv = fv; v.pc = pc; v.dr = dr; v.rd = rd; v.rst_n = rst_n;
    v.ec = ec; v.efr = efr; v.edv = edv; v.epc = epc; v.zchk = zchk;
    tbl.push_back(v);
  endtask

  task automatic go_idle();
    rst_aL               = 1'b1;
    fetch_ififo_valid    = 1'b0;
    ififo_dispatch_ready = 1'b0;
    fetch_redirect_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".count"}, 128'(ififo_count), 128'(v.ec));
    check({tag, ".fetch_ready"}, 128'(fetch_ififo_ready), 128'(v.efr));
    check({tag, ".disp_valid"}, 128'(ififo_dispatch_valid), 128'(v.edv));
    if (v.edv)
      check({tag, ".disp_data"}, 128'(ififo_dispatch_data), 128'(mk_entry(v.epc)));
    if (v.zchk)
      check({tag, ".disp_data_zero"}, 128'(ififo_dispatch_data), 128'd0);
  endtask

  initial begin
    // Reset, enqueue three, then drain in order.
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 32'h0, 0, 0, 1, 1, 1, 1, 32'h0, 0);
    add(1, 32'h4, 0, 0, 1, 2, 1, 1, 32'h0, 0);
    add(1, 32'h8, 0, 0, 1, 3, 1, 1, 32'h0, 0);
    add(0, 0, 1, 0, 1, 2, 1, 1, 32'h4, 0);
    add(0, 0, 1, 0, 1, 1, 1, 1, 32'h8, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    // Fill to full, drop an extra enq, then full + deq gives no enq.
    for (int i = 0; i < 8; i++)
      add(1, 32'h100 + 32'(4 * i), 0, 0, 1, 4'(i + 1), (i != 7), 1, 32'h100, 0);
    add(1, 32'h200, 0, 0, 1, 8, 0, 1, 32'h100, 0);
    add(1, 32'h204, 1, 0, 1, 7, 1, 1, 32'h104, 0);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 0, 1, 4'(6 - i), 1, (i != 6), 32'h108 + 32'(4 * i), 0);
    // Continuous stream across pointer wrap.
    for (int i = 0; i < 20; i++)
      add(1, 32'h1000 + 32'(4 * i), 1, 0, 1, 1, 1, 1, 32'h1000 + 32'(4 * i), 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    // Flush with concurrent enq/deq; redirect target enqueued next cycle.
    for (int i = 0; i < 5; i++)
      add(1, 32'h300 + 32'(4 * i), 0, 0, 1, 4'(i + 1), 1, 1, 32'h300, 0);
    add(1, 32'h400, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 32'h500, 0, 0, 1, 1, 1, 1, 32'h500, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    // Reset mid-stream with activity on all other inputs.
    for (int i = 0; i < 4; i++)
      add(1, 32'h600 + 32'(4 * i), 0, 0, 1, 4'(i + 1), 1, 1, 32'h600, 0);
    add(1, 32'h680, 1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 32'h700, 0, 0, 1, 1, 1, 1, 32'h700, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_aL               = tbl[i].rst_n;
      fetch_ififo_valid    = tbl[i].fv;
      fetch_ififo_data     = mk_entry(tbl[i].pc);
      ififo_dispatch_ready = tbl[i].dr;
      fetch_redirect_valid = tbl[i].rd;
      @(posedge clk);
      #1;
      go_idle();
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i]);
    end

    // Empty-FIFO latency: bypass makes the entry visible before the edge.
    begin
      vec_t v;
      fetch_ififo_valid    = 1'b1;
      fetch_ififo_data     = mk_entry(32'h800);
      ififo_dispatch_ready = 1'b1;
      #2;
`ifdef IFIFO_BYPASS_EN
      check("bypass.valid", 128'(ififo_dispatch_valid), 128'd1);
      check("bypass.data", 128'(ififo_dispatch_data), 128'(mk_entry(32'h800)));
      @(posedge clk);
      #1;
      go_idle();
      #1;
      v = '{fv: 0, pc: 0, dr: 0, rd: 0, rst_n: 1, ec: 0, efr: 1, edv: 0, epc: 0, zchk: 0};
      check_outputs("bypass.after", v);
`else
      check("latency.valid_before", 128'(ififo_dispatch_valid), 128'd0);
      @(posedge clk);
      #1;
      go_idle();
      #1;
      v = '{fv: 0, pc: 0, dr: 0, rd: 0, rst_n: 1, ec: 1, efr: 1, edv: 1, epc: 32'h800, zchk: 0};
      check_outputs("latency.after", v);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
